// File: rtl/bp_stall_profile_counters_pkg.sv
// Shared types and constants for the stall-reason profiler: reason names,
// snapshot word offsets past the reason block, and the drain FSM states.
package bp_stall_profile_counters_pkg;

  localparam int bp_num_reasons_lp = 24;

  // Lowest encoding is the highest-priority reason; e_unknown closes the list.
  typedef enum logic [4:0] {
    e_icache_miss, e_itlb_miss, e_branch_mispredict, e_fetch_redirect,
    e_icache_fence, e_decode_stall, e_queue_full, e_dcache_miss,
    e_dtlb_miss, e_load_dep, e_mul_busy, e_fpu_busy,
    e_div_busy, e_struct_haz, e_ctrl_haz, e_fence,
    e_csr_wait, e_exception, e_interrupt, e_mem_order,
    e_lsq_full, e_rob_full, e_long_haz, e_replay,
    e_unknown
  } bp_stall_reason_e;

  localparam int snap_unknown_ofs_lp = 0;
  localparam int snap_instret_ofs_lp = 1;
  localparam int snap_cycles_ofs_lp  = 2;
  localparam int snap_extra_words_lp = 3;

  typedef enum logic {e_idle, e_drain} snap_state_e;

endpackage

// File: rtl/bp_stall_profile_counters_if.sv
// Snapshot stream: one word per cycle, valid/ready, last flags the cycles word.
interface bp_stall_profile_counters_if #(
  parameter int idx_width_p = 5,
  parameter int cnt_width_p = 32
);
  logic                   snap_v_o;
  logic                   snap_ready_i;
  logic [idx_width_p-1:0] snap_idx_o;
  logic [cnt_width_p-1:0] snap_data_o;
  logic                   snap_last_o;

  modport master (output snap_v_o, snap_idx_o, snap_data_o, snap_last_o,
                  input  snap_ready_i);
  modport slave  (input  snap_v_o, snap_idx_o, snap_data_o, snap_last_o,
                  output snap_ready_i);
endinterface

// File: rtl/bp_stall_profile_counters_attr_pipe.sv
// OR-shift attribution pipeline: a reason raised at any stage travels with
// its slot to commit; the oldest slot is priority-encoded, index 0 first.
module bp_stall_attr_pipe
  import bp_stall_profile_counters_pkg::*;
#(
  parameter  int num_stages_p  = 8,
  parameter  int num_reasons_p = 24,
  localparam int ridx_w_lp     = $clog2(num_reasons_p + 1)
) (
  input  logic                                  clk_i,
  input  logic                                  reset_n_i,
  input  logic [num_stages_p*num_reasons_p-1:0] stage_event_i,
  output logic [ridx_w_lp-1:0]                  reason_idx_o,
  output logic                                  any_v_o
);

  logic [num_stages_p-1:0][num_reasons_p-1:0] ev, stage_q, stage_d;
  logic [num_reasons_p-1:0]                   attr;

  assign ev = stage_event_i;

  always_comb begin
    stage_d    = '0;
    stage_d[0] = ev[0];
    for (int s = 1; s < num_stages_p; s++)
      stage_d[s] = stage_q[s-1] | ev[s];
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) stage_q <= '0;
    else            stage_q <= stage_d;
  end

  assign attr    = stage_q[num_stages_p-1];
  assign any_v_o = |attr;

  always_comb begin
    reason_idx_o = '0;
    for (int i = num_reasons_p - 1; i >= 0; i--)
      if (attr[i]) reason_idx_o = ridx_w_lp'(i);
  end

endmodule

// File: rtl/bp_stall_profile_counters.sv
// Saturating stall/instret/cycle counters with optional windowing; snapshots
// are copied to a shadow bank and streamed out one word per handshake.
module bp_stall_profile_counters
  import bp_stall_profile_counters_pkg::*;
#(
  parameter int num_stages_p  = 8,
  parameter int num_reasons_p = 24,
  parameter int cnt_width_p   = 32,
  parameter int win_width_p   = 24
) (
  input  logic                                  clk_i,
  input  logic                                  reset_n_i,
  input  logic                                  enable_i,
  input  logic                                  clear_i,
  input  logic                                  mode_i,
  input  logic [win_width_p-1:0]                window_len_i,
  input  logic                                  snap_req_i,
  input  logic [num_stages_p*num_reasons_p-1:0] stage_event_i,
  input  logic                                  commit_v_i,
  bp_stall_profile_counters_if.master           snap_if,
  output logic                                  overrun_o
);

  localparam int words_lp  = num_reasons_p + snap_extra_words_lp;
  localparam int idx_w_lp  = $clog2(words_lp);
  localparam int ridx_w_lp = $clog2(num_reasons_p + 1);
  localparam int unk_lp    = num_reasons_p + snap_unknown_ofs_lp;
  localparam int ins_lp    = num_reasons_p + snap_instret_ofs_lp;
  localparam int cyc_lp    = num_reasons_p + snap_cycles_ofs_lp;
  localparam logic [idx_w_lp-1:0] last_idx_lp = idx_w_lp'(words_lp - 1);

  logic [ridx_w_lp-1:0] reason_idx;
  logic                 attr_v;

  bp_stall_attr_pipe #(
    .num_stages_p (num_stages_p),
    .num_reasons_p(num_reasons_p)
  ) u_attr (
    .clk_i        (clk_i),
    .reset_n_i    (reset_n_i),
    .stage_event_i(stage_event_i),
    .reason_idx_o (reason_idx),
    .any_v_o      (attr_v)
  );

  // One-hot increment in shadow-bank word order.
  logic [words_lp-1:0] inc;
  always_comb begin
    inc = '0;
    if (enable_i) begin
      inc[cyc_lp] = 1'b1;
      if (commit_v_i)  inc[ins_lp] = 1'b1;
      else if (attr_v) inc[idx_w_lp'(reason_idx)] = 1'b1;
      else             inc[unk_lp] = 1'b1;
    end
  end

  logic [win_width_p-1:0] win_cnt_q, win_cnt_d, win_last;
  logic                   win_end;

  assign win_last = (window_len_i == '0) ? '0 : window_len_i - win_width_p'(1);
  assign win_end  = mode_i & enable_i & (win_cnt_q == win_last);

  always_comb begin
    win_cnt_d = win_cnt_q;
    if (clear_i || !mode_i || win_end) win_cnt_d = '0;
    else if (enable_i)                 win_cnt_d = win_cnt_q + win_width_p'(1);
  end

  logic [words_lp-1:0][cnt_width_p-1:0] live_q, live_d, shadow_q, shadow_d;

  // A window end restarts each counter at this cycle's increment.
  always_comb begin
    live_d = live_q;
    for (int w = 0; w < words_lp; w++) begin
      if (clear_i)                         live_d[w] = '0;
      else if (win_end)                    live_d[w] = cnt_width_p'(inc[w]);
      else if (inc[w] && !(&live_q[w]))    live_d[w] = live_q[w] + cnt_width_p'(1);
    end
  end

  snap_state_e         state_q, state_d;
  logic [idx_w_lp-1:0] idx_q, idx_d;
  logic                trigger, capture, drop, overrun_q, overrun_d;

  assign trigger = win_end | snap_req_i;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    capture = 1'b0;
    drop    = 1'b0;
    case (state_q)
      e_idle: begin
        if (trigger) begin
          capture = 1'b1;
          state_d = e_drain;
          idx_d   = '0;
        end
      end
      e_drain: begin
        drop = trigger;
        if (snap_if.snap_ready_i) begin
          if (idx_q == last_idx_lp) begin
            state_d = e_idle;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + idx_w_lp'(1);
          end
        end
      end
      default: state_d = e_idle;
    endcase
  end

  assign shadow_d  = capture ? live_q : shadow_q;
  assign overrun_d = drop | (overrun_q & ~clear_i);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      win_cnt_q <= '0;
      live_q    <= '0;
      shadow_q  <= '0;
      state_q   <= e_idle;
      idx_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      win_cnt_q <= win_cnt_d;
      live_q    <= live_d;
      shadow_q  <= shadow_d;
      state_q   <= state_d;
      idx_q     <= idx_d;
      overrun_q <= overrun_d;
    end
  end

  assign snap_if.snap_v_o    = (state_q == e_drain);
  assign snap_if.snap_last_o = (state_q == e_drain) && (idx_q == last_idx_lp);
  assign snap_if.snap_idx_o  = idx_q;
  assign snap_if.snap_data_o = shadow_q[idx_q];
  assign overrun_o           = overrun_q;

endmodule

// File: tb/tb_bp_stall_profile_counters.sv
// Directed bench: expected snapshot words are queued when a snapshot is
// triggered; per-DUT monitors pop and compare on every accepted word.
module tb_bp_stall_profile_counters;

  localparam int NS  = 8;
  localparam int NR  = 24;
  localparam int NW  = NR + 3;
  localparam int IW  = 5;
  localparam int UNK = NR;
  localparam int INS = NR + 1;
  localparam int CYC = NR + 2;

  typedef struct {
    int          idx;
    logic [31:0] data;
    bit          last;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n, en_a, en_b, clear, mode, snap_a, snap_b, commit;
  logic [23:0]      wlen;
  logic [NS*NR-1:0] sev;
  logic             ovr_a, ovr_b;

  bp_stall_profile_counters_if #(.idx_width_p(IW), .cnt_width_p(32)) ifa ();
  bp_stall_profile_counters_if #(.idx_width_p(IW), .cnt_width_p(4))  ifb ();

  bp_stall_profile_counters #(
    .num_stages_p(NS), .num_reasons_p(NR), .cnt_width_p(32), .win_width_p(24)
  ) dut_a (
    .clk_i(clk), .reset_n_i(rst_n), .enable_i(en_a), .clear_i(clear),
    .mode_i(mode), .window_len_i(wlen), .snap_req_i(snap_a),
    .stage_event_i(sev), .commit_v_i(commit), .snap_if(ifa), .overrun_o(ovr_a)
  );

  bp_stall_profile_counters #(
    .num_stages_p(NS), .num_reasons_p(NR), .cnt_width_p(4), .win_width_p(24)
  ) dut_b (
    .clk_i(clk), .reset_n_i(rst_n), .enable_i(en_b), .clear_i(clear),
    .mode_i(mode), .window_len_i(wlen), .snap_req_i(snap_b),
    .stage_event_i(sev), .commit_v_i(commit), .snap_if(ifb), .overrun_o(ovr_b)
  );

  int          checks = 0;
  int          fails  = 0;
  exp_t        qa[$];
  exp_t        qb[$];
  logic [31:0] ex [NW];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  task automatic cmp_word(input string tag, input exp_t e, input logic [IW-1:0] idx,
                          input logic [31:0] data, input logic last);
    checks++;
    if (idx !== IW'(e.idx) || data !== e.data || last !== e.last) begin
      fails++;
      $display("FAIL %s_word: got idx=%0d data=0x%0h last=%0b, want idx=%0d data=0x%0h last=%0b",
               tag, idx, data, last, e.idx, e.data, e.last);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && ifa.snap_v_o && ifa.snap_ready_i) begin
      if (qa.size() == 0) begin
        checks++; fails++;
        $display("FAIL a_extra_word: got idx=%0d, want no word", ifa.snap_idx_o);
      end else begin
        cmp_word("a", qa.pop_front(), ifa.snap_idx_o, ifa.snap_data_o, ifa.snap_last_o);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && ifb.snap_v_o && ifb.snap_ready_i) begin
      if (qb.size() == 0) begin
        checks++; fails++;
        $display("FAIL b_extra_word: got idx=%0d, want no word", ifb.snap_idx_o);
      end else begin
        cmp_word("b", qb.pop_front(), ifb.snap_idx_o, 32'(ifb.snap_data_o), ifb.snap_last_o);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ex_zero();
    foreach (ex[i]) ex[i] = '0;
  endtask

  task automatic push_a(input int n);
    for (int i = 0; i < n; i++) qa.push_back('{idx: i, data: ex[i], last: (i == NW - 1)});
  endtask

  task automatic push_b(input int n);
    for (int i = 0; i < n; i++) qb.push_back('{idx: i, data: ex[i], last: (i == NW - 1)});
  endtask

  task automatic run_a(input int n);
    en_a = 1'b1;
    repeat (n) step();
    en_a = 1'b0;
  endtask

  task automatic req_a();
    snap_a = 1'b1;
    step();
    snap_a = 1'b0;
  endtask

  task automatic clr();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic wait_a(input string name);
    for (int i = 0; i < 100 && (qa.size() != 0 || ifa.snap_v_o); i++) step();
    chk({name, "_pending"}, 32'(qa.size()), 32'd0);
    chk({name, "_idle"}, 32'(ifa.snap_v_o), 32'd0);
  endtask

  task automatic wait_b(input string name);
    for (int i = 0; i < 100 && (qb.size() != 0 || ifb.snap_v_o); i++) step();
    chk({name, "_pending"}, 32'(qb.size()), 32'd0);
    chk({name, "_idle"}, 32'(ifb.snap_v_o), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; en_a = 1'b0; en_b = 1'b0; clear = 1'b0; mode = 1'b0;
    snap_a = 1'b0; snap_b = 1'b0; commit = 1'b0; wlen = '0; sev = '0;
    ifa.snap_ready_i = 1'b1;
    ifb.snap_ready_i = 1'b1;
    step(); step();

    chk("rst_v",    32'(ifa.snap_v_o),    32'd0);
    chk("rst_last", 32'(ifa.snap_last_o), 32'd0);
    chk("rst_idx",  32'(ifa.snap_idx_o),  32'd0);
    chk("rst_data", ifa.snap_data_o,      32'd0);
    chk("rst_ovr",  32'(ovr_a),           32'd0);
    chk("rst_b_v",  32'(ifb.snap_v_o),    32'd0);
    rst_n = 1'b1;
    step();

    // 100 unattributed cycles, then a software snapshot.
    run_a(100);
    ex_zero(); ex[UNK] = 100; ex[CYC] = 100; push_a(NW);
    req_a();
    wait_a("t1");

    // Stage-0 reason 5 counts on the 9th enabled edge, exactly once.
    clr();
    ex_zero(); ex[5] = 1; ex[UNK] = 8; ex[CYC] = 9; push_a(NW);
    en_a = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      sev = '0;
      snap_a = (e == 10);
      if (e == 1) sev[5] = 1'b1;
      step();
    end
    sev = '0; snap_a = 1'b0; en_a = 1'b0;
    wait_a("t2a_mid");
    ex[UNK] = 9; ex[CYC] = 10; push_a(NW);
    req_a();
    wait_a("t2a_end");

    // Priority encode, stage-7 injection, commit beating an attributed reason.
    clr();
    ex_zero(); ex[2] = 1; ex[INS] = 1; ex[UNK] = 6; ex[CYC] = 8; push_a(NW);
    en_a = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      sev = '0;
      commit = (e == 4);
      snap_a = (e == 9);
      if (e == 1) begin
        sev[3] = 1'b1; sev[5] = 1'b1; sev[7*NR+2] = 1'b1;
      end
      if (e == 3) sev[7*NR+7] = 1'b1;
      step();
    end
    sev = '0; commit = 1'b0; snap_a = 1'b0; en_a = 1'b0;
    wait_a("t2b_mid");
    ex[3] = 1; ex[UNK] = 9; ex[CYC] = 12; push_a(NW);
    req_a();
    wait_a("t2b_end");

    // Windowed mode; the first window after clear sees len-1 cycles.
    mode = 1'b1; wlen = 24'd30; commit = 1'b1;
    clr();
    ex_zero(); ex[INS] = 29; ex[CYC] = 29; push_a(NW);
    run_a(30);
    wait_a("t3_w1");
    ex[INS] = 1; ex[CYC] = 1; push_a(NW);
    req_a();
    wait_a("t3_roll");
    ex[INS] = 30; ex[CYC] = 30; push_a(NW);
    run_a(30);
    wait_a("t3_w2");
    wlen = '0;
    ex[INS] = 1; ex[CYC] = 1; push_a(NW);
    run_a(1);
    wait_a("t3_len0");

    // Stalled consumer across two window ends: second snapshot dropped.
    wlen = 24'd30;
    clr();
    ifa.snap_ready_i = 1'b0;
    ex_zero(); ex[INS] = 29; ex[CYC] = 29; push_a(NW);
    run_a(60);
    chk("t4_ovr_set", 32'(ovr_a),          32'd1);
    chk("t4_hold_v",  32'(ifa.snap_v_o),   32'd1);
    chk("t4_hold_idx", 32'(ifa.snap_idx_o), 32'd0);
    ifa.snap_ready_i = 1'b1;
    wait_a("t4_drain");
    chk("t4_ovr_sticky", 32'(ovr_a), 32'd1);
    ex_zero(); ex[INS] = 1; ex[CYC] = 1; push_a(NW);
    clear = 1'b1; snap_a = 1'b1;
    step();
    clear = 1'b0; snap_a = 1'b0;
    chk("t4_ovr_clr", 32'(ovr_a), 32'd0);
    wait_a("t4_preclear");
    ex_zero(); push_a(NW);
    req_a();
    wait_a("t4_postclear");
    mode = 1'b0; commit = 1'b0;

    // 4-bit counters saturate at 15.
    ex_zero(); ex[0] = 15; ex[UNK] = 8; ex[CYC] = 15; push_b(NW);
    sev[0] = 1'b1; en_b = 1'b1;
    repeat (30) step();
    en_b = 1'b0; sev = '0;
    snap_b = 1'b1;
    step();
    snap_b = 1'b0;
    wait_b("t5");

    // Reset at idx 4 of a drain abandons it and zeroes the counters.
    run_a(5);
    ex_zero(); push_a(4);
    req_a();
    repeat (4) step();
    ifa.snap_ready_i = 1'b0;
    chk("t6_pre_v",   32'(ifa.snap_v_o),   32'd1);
    chk("t6_pre_idx", 32'(ifa.snap_idx_o), 32'd4);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_v",    32'(ifa.snap_v_o),    32'd0);
    chk("t6_rst_last", 32'(ifa.snap_last_o), 32'd0);
    chk("t6_rst_idx",  32'(ifa.snap_idx_o),  32'd0);
    chk("t6_rst_data", ifa.snap_data_o,      32'd0);
    step();
    rst_n = 1'b1;
    ifa.snap_ready_i = 1'b1;
    ex_zero(); push_a(NW);
    req_a();
    wait_a("t6_after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
